int_branch_recovery_arbiter: RTL and testbench
==============================================

Name: int_branch_recovery_arbiter

Overview:
- Collects branch-mispredict results from all integer execution lanes each cycle and selects the oldest one by active-list age.
- Holds the selected mispredict as a recovery request to the recovery manager until it is acknowledged, then tracks the recovery phase until it completes.
- Captures any older mispredict that arrives while a request is outstanding, so no architecturally needed recovery is lost.
- Sits between the integer execution stages and the recovery manager.

Parameters:
ISSUE_WIDTH, 2, number of integer execution lanes
AL_PTR_WIDTH, 6, active-list pointer width (active list depth = 2**AL_PTR_WIDTH)
ADDR_WIDTH, 32, PC/target address width
CNT_WIDTH, 16, width of the mispredict statistics counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
stall  in  1  backend stall; lane inputs are ignored while high
lane_valid  in  ISSUE_WIDTH  lane carries a valid, unflushed branch result
lane_mispred  in  ISSUE_WIDTH  branch result is mispredicted
lane_al_ptr  in  ISSUE_WIDTH*AL_PTR_WIDTH  active-list pointer of each lane's op
lane_next_addr  in  ISSUE_WIDTH*ADDR_WIDTH  correct next PC of each lane's op
al_head_ptr  in  AL_PTR_WIDTH  active-list head (oldest op)
req_valid  out  1  recovery request pending
req_al_ptr  out  AL_PTR_WIDTH  active-list pointer of the mispredicted branch
req_next_addr  out  ADDR_WIDTH  refetch PC
req_ack  in  1  recovery manager accepts the request this cycle
recovery_done  in  1  one-cycle pulse: recovery phase finished
busy  out  1  state != IDLE
mispred_count  out  CNT_WIDTH  saturating count of accepted requests

Behaviour:
- Reset (rst=0, asynchronous) values: state=IDLE, req_valid=0, req_al_ptr=0, req_next_addr=0, busy=0, mispred_count=0, pending slot invalid.
- Candidate lane i: lane_valid[i] & lane_mispred[i] & !stall.
- Age of a pointer p = (p - al_head_ptr) mod 2**AL_PTR_WIDTH. A smaller age is older.
- Lane selection: the candidate with the smallest age wins. On equal age, the lower lane index wins. Selection is combinational, but the winner is registered, so req_valid rises the cycle after the candidate is seen (1-cycle latency).
- States:
  - IDLE: if any candidate, load the winner into the held registers and go to REQ.
  - REQ: req_valid=1; outputs show the held entry.
    - Without req_ack: an incoming winner strictly older than the held entry replaces it. Younger or equal winners are dropped, since they will be flushed.
    - With req_ack: go to RECOVER and increment mispred_count (saturates at all ones). If an incoming winner in the same cycle is strictly older than the acked entry, store it in the pending slot; otherwise drop it.
    - req_al_ptr and req_next_addr never change in a cycle where req_ack=1.
  - RECOVER: req_valid=0.
    - A winner strictly older than the entry under recovery goes to the pending slot. If the slot is already full, the older of the two is kept.
    - Younger winners are dropped.
    - On recovery_done: if the pending slot is valid, move it to the held registers and go to REQ (req_valid=1 the next cycle), clear the pending slot. Otherwise go to IDLE.
    - A winner arriving in the same cycle as recovery_done is compared against the pending entry if one exists, else taken as the new held entry.
- recovery_done in IDLE or REQ is ignored.
- Pointer wrap-around is handled only through the modular age. Pointers are never compared raw.
- Stall=1 freezes candidate intake only. The state machine still reacts to req_ack and recovery_done.
- busy = (state != IDLE).

Test Plan:
1. Reset mid-REQ (held ptr=5, req_valid=1), then rst=0 for 1 cycle → req_valid=0, req_al_ptr=0, mispred_count=0 immediately, without waiting for a clock edge.
2. head=0; lane0 ptr=9, lane1 ptr=4, both mispredicted, next_addr 0x100/0x200 → next cycle req_valid=1, req_al_ptr=4, req_next_addr=0x200.
3. Wrap-around: head=60; lane0 ptr=2 (age 6), lane1 ptr=62 (age 2) → req_al_ptr=62.
4. In REQ (held ptr=10, head=0), lane0 ptr=7 arrives without req_ack → req_al_ptr becomes 7. Then lane1 ptr=12 arrives → dropped, req_al_ptr stays 7.
5. req_ack with held ptr=10 while lane0 ptr=3 arrives in the same cycle → RECOVER, pending=3, mispred_count=1. On recovery_done → REQ with req_al_ptr=3. Second req_ack → mispred_count=2.
6. stall=1 with lane0 valid mispredict ptr=1 in IDLE → req_valid stays 0. Counter preset to 0xFFFF plus one more ack → mispred_count stays 0xFFFF.

Source files
------------

// File: rtl/int_branch_recovery_arbiter.sv
// Picks the oldest integer-lane mispredict and holds it as a recovery
// request, parking an older late arrival until recovery completes.
module int_branch_recovery_arbiter #(
  parameter int ISSUE_WIDTH  = 2,
  parameter int AL_PTR_WIDTH = 6,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                stall,
  input  logic [ISSUE_WIDTH-1:0]              lane_valid,
  input  logic [ISSUE_WIDTH-1:0]              lane_mispred,
  input  logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0] lane_al_ptr,
  input  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]   lane_next_addr,
  input  logic [AL_PTR_WIDTH-1:0]             al_head_ptr,
  output logic                                req_valid,
  output logic [AL_PTR_WIDTH-1:0]             req_al_ptr,
  output logic [ADDR_WIDTH-1:0]               req_next_addr,
  input  logic                                req_ack,
  input  logic                                recovery_done,
  output logic                                busy,
  output logic [CNT_WIDTH-1:0]                mispred_count
);

  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t state, stateNxt;

  logic [AL_PTR_WIDTH-1:0] heldPtr, heldPtrNxt;
  logic [ADDR_WIDTH-1:0]   heldAddr, heldAddrNxt;
  logic                    pendValid, pendValidNxt;
  logic [AL_PTR_WIDTH-1:0] pendPtr, pendPtrNxt;
  logic [ADDR_WIDTH-1:0]   pendAddr, pendAddrNxt;
  logic [CNT_WIDTH-1:0]    cnt, cntNxt, cntSat;

  logic [AL_PTR_WIDTH-1:0] lanePtr  [ISSUE_WIDTH];
  logic [AL_PTR_WIDTH-1:0] laneAge  [ISSUE_WIDTH];
  logic [ADDR_WIDTH-1:0]   laneAddr [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0]  cand;

  logic                    winValid;
  logic [AL_PTR_WIDTH-1:0] winPtr, winAge;
  logic [ADDR_WIDTH-1:0]   winAddr;
  logic [AL_PTR_WIDTH-1:0] heldAge, pendAge;
  logic                    winOlderHeld, winOlderPend;

  // unpack lanes and compute modular age against the active-list head
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lanePtr[i]  = lane_al_ptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH];
      laneAddr[i] = lane_next_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      laneAge[i]  = lanePtr[i] - al_head_ptr;
      cand[i]     = lane_valid[i] & lane_mispred[i] & ~stall;
    end
  end

  // oldest candidate wins; strict compare keeps the lower lane on ties
  always_comb begin
    winValid = 1'b0;
    winPtr   = '0;
    winAge   = '0;
    winAddr  = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (cand[i] && (!winValid || laneAge[i] < winAge)) begin
        winValid = 1'b1;
        winPtr   = lanePtr[i];
        winAge   = laneAge[i];
        winAddr  = laneAddr[i];
      end
    end
  end

  assign heldAge      = heldPtr - al_head_ptr;
  assign pendAge      = pendPtr - al_head_ptr;
  assign winOlderHeld = winValid && (winAge < heldAge);
  assign winOlderPend = winAge < pendAge;
  assign cntSat       = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CntOne;

  // request / recovery sequencing and held/pending slot updates
  always_comb begin
    stateNxt     = state;
    heldPtrNxt   = heldPtr;
    heldAddrNxt  = heldAddr;
    pendValidNxt = pendValid;
    pendPtrNxt   = pendPtr;
    pendAddrNxt  = pendAddr;
    cntNxt       = cnt;
    unique case (state)
      IDLE: begin
        if (winValid) begin
          heldPtrNxt  = winPtr;
          heldAddrNxt = winAddr;
          stateNxt    = REQ;
        end
      end
      REQ: begin
        if (req_ack) begin
          stateNxt = RECOVER;
          cntNxt   = cntSat;
          if (winOlderHeld) begin
            pendValidNxt = 1'b1;
            pendPtrNxt   = winPtr;
            pendAddrNxt  = winAddr;
          end
        end else if (winOlderHeld) begin
          heldPtrNxt  = winPtr;
          heldAddrNxt = winAddr;
        end
      end
      RECOVER: begin
        if (recovery_done) begin
          pendValidNxt = 1'b0;
          if (pendValid) begin
            stateNxt = REQ;
            if (winOlderHeld && winOlderPend) begin
              heldPtrNxt  = winPtr;
              heldAddrNxt = winAddr;
            end else begin
              heldPtrNxt  = pendPtr;
              heldAddrNxt = pendAddr;
            end
          end else if (winOlderHeld) begin
            stateNxt    = REQ;
            heldPtrNxt  = winPtr;
            heldAddrNxt = winAddr;
          end else begin
            stateNxt = IDLE;
          end
        end else if (winOlderHeld && (!pendValid || winOlderPend)) begin
          pendValidNxt = 1'b1;
          pendPtrNxt   = winPtr;
          pendAddrNxt  = winAddr;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // state and slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      heldPtr   <= '0;
      heldAddr  <= '0;
      pendValid <= 1'b0;
      pendPtr   <= '0;
      pendAddr  <= '0;
      cnt       <= '0;
    end else begin
      state     <= stateNxt;
      heldPtr   <= heldPtrNxt;
      heldAddr  <= heldAddrNxt;
      pendValid <= pendValidNxt;
      pendPtr   <= pendPtrNxt;
      pendAddr  <= pendAddrNxt;
      cnt       <= cntNxt;
    end
  end

  assign req_valid     = (state == REQ);
  assign req_al_ptr    = heldPtr;
  assign req_next_addr = heldAddr;
  assign busy          = (state != IDLE);
  assign mispred_count = cnt;

endmodule

// File: tb/tb_int_branch_recovery_arbiter.sv
// Directed bench for int_branch_recovery_arbiter: oldest-lane select,
// wrap-around age, replace/pend behaviour, stall and counter saturation.
module tb_int_branch_recovery_arbiter;

  localparam int IW = 2;
  localparam int AP = 6;
  localparam int AW = 32;
  // narrow counter so saturation is reachable in a short run
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          stall;
  logic [IW-1:0] lane_valid;
  logic [IW-1:0] lane_mispred;
  logic [IW*AP-1:0] lane_al_ptr;
  logic [IW*AW-1:0] lane_next_addr;
  logic [AP-1:0] al_head_ptr;
  logic          req_valid;
  logic [AP-1:0] req_al_ptr;
  logic [AW-1:0] req_next_addr;
  logic          req_ack;
  logic          recovery_done;
  logic          busy;
  logic [CW-1:0] mispred_count;

  int checks = 0;
  int errors = 0;

  int_branch_recovery_arbiter #(
    .ISSUE_WIDTH(IW),
    .AL_PTR_WIDTH(AP),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .lane_valid(lane_valid),
    .lane_mispred(lane_mispred),
    .lane_al_ptr(lane_al_ptr),
    .lane_next_addr(lane_next_addr),
    .al_head_ptr(al_head_ptr),
    .req_valid(req_valid),
    .req_al_ptr(req_al_ptr),
    .req_next_addr(req_next_addr),
    .req_ack(req_ack),
    .recovery_done(recovery_done),
    .busy(busy),
    .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLane(input int i, input logic [AP-1:0] p,
                         input logic [AW-1:0] a);
    lane_valid[i]   = 1'b1;
    lane_mispred[i] = 1'b1;
    lane_al_ptr[i*AP +: AP]    = p;
    lane_next_addr[i*AW +: AW] = a;
  endtask

  task automatic clearLanes();
    lane_valid     = '0;
    lane_mispred   = '0;
    lane_al_ptr    = '0;
    lane_next_addr = '0;
  endtask

  task automatic finishRecovery();
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    recovery_done = 1'b1;
    tick();
    recovery_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall = 1'b0;
    req_ack = 1'b0;
    recovery_done = 1'b0;
    al_head_ptr = '0;
    clearLanes();
    repeat (2) tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", req_valid); end
    checks++; if (req_al_ptr !== 6'd0) begin errors++; $display("FAIL rst_ptr: got %0d expected 0", req_al_ptr); end
    checks++; if (req_next_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h expected 0", req_next_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (mispred_count !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", mispred_count); end
    rst = 1'b1;
    tick();
    setLane(0, 6'd5, 32'h55);
    tick();
    clearLanes();
    finishRecovery();
    setLane(0, 6'd5, 32'h55);
    tick();
    clearLanes();
    checks++; if (req_valid !== 1'b1 || req_al_ptr !== 6'd5) begin errors++; $display("FAIL pre_rst_req: got v=%0b p=%0d expected v=1 p=5", req_valid, req_al_ptr); end
    checks++; if (mispred_count !== 8'd1) begin errors++; $display("FAIL pre_rst_cnt: got %0d expected 1", mispred_count); end
    rst = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %0b expected 0", req_valid); end
    checks++; if (req_al_ptr !== 6'd0) begin errors++; $display("FAIL async_ptr: got %0d expected 0", req_al_ptr); end
    checks++; if (mispred_count !== 8'd0) begin errors++; $display("FAIL async_cnt: got %0d expected 0", mispred_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %0b expected 0", busy); end
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_select();
    al_head_ptr = 6'd0;
    setLane(0, 6'd9, 32'h100);
    setLane(1, 6'd4, 32'h200);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL sel_latency: got %0b expected 0", req_valid); end
    tick();
    clearLanes();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL sel_valid: got %0b expected 1", req_valid); end
    checks++; if (req_al_ptr !== 6'd4) begin errors++; $display("FAIL sel_ptr: got %0d expected 4", req_al_ptr); end
    checks++; if (req_next_addr !== 32'h200) begin errors++; $display("FAIL sel_addr: got %h expected 200", req_next_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sel_busy: got %0b expected 1", busy); end
    finishRecovery();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sel_idle: got %0b expected 0", busy); end
    checks++; if (mispred_count !== 8'd1) begin errors++; $display("FAIL sel_cnt: got %0d expected 1", mispred_count); end
  endtask

  task automatic test_tie();
    al_head_ptr = 6'd0;
    setLane(0, 6'd7, 32'h70);
    setLane(1, 6'd7, 32'h77);
    tick();
    clearLanes();
    checks++; if (req_next_addr !== 32'h70) begin errors++; $display("FAIL tie_addr: got %h expected 70", req_next_addr); end
    finishRecovery();
  endtask

  task automatic test_wrap();
    al_head_ptr = 6'd60;
    setLane(0, 6'd2, 32'h300);
    setLane(1, 6'd62, 32'h400);
    tick();
    clearLanes();
    checks++; if (req_al_ptr !== 6'd62) begin errors++; $display("FAIL wrap_ptr: got %0d expected 62", req_al_ptr); end
    checks++; if (req_next_addr !== 32'h400) begin errors++; $display("FAIL wrap_addr: got %h expected 400", req_next_addr); end
    finishRecovery();
    checks++; if (mispred_count !== 8'd3) begin errors++; $display("FAIL wrap_cnt: got %0d expected 3", mispred_count); end
  endtask

  task automatic test_replace();
    al_head_ptr = 6'd0;
    setLane(0, 6'd10, 32'hA0);
    tick();
    clearLanes();
    setLane(0, 6'd7, 32'h70);
    tick();
    clearLanes();
    checks++; if (req_al_ptr !== 6'd7 || req_next_addr !== 32'h70) begin errors++; $display("FAIL repl_older: got p=%0d a=%h expected p=7 a=70", req_al_ptr, req_next_addr); end
    setLane(1, 6'd12, 32'hC0);
    tick();
    clearLanes();
    checks++; if (req_al_ptr !== 6'd7) begin errors++; $display("FAIL repl_younger: got %0d expected 7", req_al_ptr); end
    setLane(0, 6'd7, 32'hEE);
    recovery_done = 1'b1;
    tick();
    recovery_done = 1'b0;
    clearLanes();
    checks++; if (req_next_addr !== 32'h70) begin errors++; $display("FAIL repl_equal: got %h expected 70", req_next_addr); end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL repl_done_ign: got %0b expected 1", req_valid); end
    finishRecovery();
    checks++; if (mispred_count !== 8'd4) begin errors++; $display("FAIL repl_cnt: got %0d expected 4", mispred_count); end
  endtask

  task automatic test_back_to_back();
    al_head_ptr = 6'd0;
    setLane(0, 6'd10, 32'h1000);
    tick();
    clearLanes();
    req_ack = 1'b1;
    setLane(0, 6'd3, 32'h3000);
    tick();
    req_ack = 1'b0;
    clearLanes();
    checks++; if (req_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_recover: got v=%0b b=%0b expected v=0 b=1", req_valid, busy); end
    checks++; if (req_al_ptr !== 6'd10) begin errors++; $display("FAIL b2b_ack_hold: got %0d expected 10", req_al_ptr); end
    checks++; if (mispred_count !== 8'd5) begin errors++; $display("FAIL b2b_cnt1: got %0d expected 5", mispred_count); end
    setLane(0, 6'd20, 32'h2020);
    tick();
    clearLanes();
    setLane(1, 6'd5, 32'h5050);
    tick();
    clearLanes();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %0b expected 0", req_valid); end
    recovery_done = 1'b1;
    tick();
    recovery_done = 1'b0;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL b2b_rereq: got %0b expected 1", req_valid); end
    checks++; if (req_al_ptr !== 6'd3 || req_next_addr !== 32'h3000) begin errors++; $display("FAIL b2b_pend: got p=%0d a=%h expected p=3 a=3000", req_al_ptr, req_next_addr); end
    finishRecovery();
    checks++; if (mispred_count !== 8'd6) begin errors++; $display("FAIL b2b_cnt2: got %0d expected 6", mispred_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_stall();
    al_head_ptr = 6'd0;
    stall = 1'b1;
    setLane(0, 6'd1, 32'h11);
    repeat (2) tick();
    checks++; if (req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got v=%0b b=%0b expected 0 0", req_valid, busy); end
    stall = 1'b0;
    tick();
    clearLanes();
    stall = 1'b1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got %0b expected 1", req_valid); end
    finishRecovery();
    stall = 1'b0;
    checks++; if (mispred_count !== 8'd7 || busy !== 1'b0) begin errors++; $display("FAIL stall_fsm: got c=%0d b=%0b expected c=7 b=0", mispred_count, busy); end
  endtask

  task automatic test_saturate();
    al_head_ptr = 6'd0;
    for (int n = 0; n < 248; n++) begin
      setLane(1, 6'd2, 32'h22);
      tick();
      clearLanes();
      finishRecovery();
    end
    checks++; if (mispred_count !== 8'hFF) begin errors++; $display("FAIL sat_reach: got %h expected ff", mispred_count); end
    setLane(1, 6'd2, 32'h22);
    tick();
    clearLanes();
    finishRecovery();
    checks++; if (mispred_count !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h expected ff", mispred_count); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_tie();
    test_wrap();
    test_replace();
    test_back_to_back();
    test_stall();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
